// File: rtl/data_memory_interface_pkg.sv
// Shared definitions for the memory-stage data interface.
// Access-type encodings match the load data decoder (funct3 style).
// Helper functions give alignment checks and byte-lane enables.
package data_memory_interface_pkg;

   // Access types: bit 2 marks the unsigned load variants
   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Undefined type codes are rejected as misaligned so they never reach the bus
   function automatic logic misaligned(input logic [2:0] i_type, input logic [1:0] i_offset);
      logic w_bad;
      case (i_type)
         MEM_B, MEM_BU: w_bad = 1'b0;
         MEM_H, MEM_HU: w_bad = i_offset[0];
         MEM_W:         w_bad = (i_offset != 2'b00);
         default:       w_bad = 1'b1;
      endcase
      return w_bad;
   endfunction

   // Stores only have signless widths
   function automatic logic store_type_ok(input logic [2:0] i_type);
      return (i_type == MEM_B) || (i_type == MEM_H) || (i_type == MEM_W);
   endfunction

   function automatic logic [3:0] byte_enable(input logic [2:0] i_type, input logic [1:0] i_offset);
      logic [3:0] w_be;
      case (i_type)
         MEM_B, MEM_BU: w_be = 4'b0001 << i_offset;
         MEM_H, MEM_HU: w_be = 4'b0011 << i_offset;
         MEM_W:         w_be = 4'b1111;
         default:       w_be = 4'b0000;
      endcase
      return w_be;
   endfunction

endpackage

// File: rtl/data_memory_interface_store_lane_encoder.sv
// Maps (type, offset, right-aligned data) to bus byte enables and lane data.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module store_lane_encoder
   import data_memory_interface_pkg::*;
(
   input  logic [2:0]  i_type,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata
);

   // Replicate the narrow datum into every lane; the enables pick the live one
   always_comb begin
      o_be    = byte_enable(i_type, i_offset);
      o_wdata = i_wdata;
      case (i_type)
         MEM_B, MEM_BU: o_wdata = {4{i_wdata[7:0]}};
         MEM_H, MEM_HU: o_wdata = {2{i_wdata[15:0]}};
         default:       o_wdata = i_wdata;
      endcase
   end

endmodule

// File: rtl/data_memory_interface.sv
// Memory-stage load/store interface: alignment check, word bus handshake, raw load return.
// Latency: bus request the cycle after accept; response one cycle after bus response.
// Backpressure: one access in flight; req_ready low until the result handshake completes.
module data_memory_interface
   import data_memory_interface_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [2:0]  rsp_type,
   output logic [1:0]  rsp_offset,
   output logic        rsp_misaligned,
   output logic        rsp_timeout
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_write;
   logic [CNT_W-1:0]   r_cnt;

   logic               r_mem_req_valid;
   logic [31:0]        r_mem_addr;
   logic               r_mem_we;
   logic [3:0]         r_mem_be;
   logic [31:0]        r_mem_wdata;

   logic               r_rsp_valid;
   logic [31:0]        r_rsp_data;
   logic [2:0]         r_rsp_type;
   logic [1:0]         r_rsp_offset;
   logic               r_rsp_misaligned;
   logic               r_rsp_timeout;

   logic               w_reject;
   logic               w_timeout_hit;
   logic [3:0]         w_enc_be;
   logic [31:0]        w_enc_wdata;

   store_lane_encoder u_store_lane_encoder (
      .i_type   (req_type),
      .i_offset (req_addr[1:0]),
      .i_wdata  (req_wdata),
      .o_be     (w_enc_be),
      .o_wdata  (w_enc_wdata)
   );

   assign w_reject = misaligned(req_type, req_addr[1:0]) |
                     (req_write & ~store_type_ok(req_type));

   // Counter reaching the limit on this WAIT cycle; a same-cycle response still wins
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                          ((32'(r_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (req_valid) w_state_nxt = w_reject ? ST_DONE : ST_REQ;
         ST_REQ:  if (mem_req_ready) w_state_nxt = ST_WAIT;
         ST_WAIT: if (mem_rsp_valid || w_timeout_hit) w_state_nxt = ST_DONE;
         ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // WAIT-cycle counter, cleared on the bus request handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == ST_REQ && mem_req_ready) begin
         r_cnt <= '0;
      end else if (r_state == ST_WAIT && !mem_rsp_valid) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Request capture, bus drive and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write          <= 1'b0;
         r_mem_req_valid  <= 1'b0;
         r_mem_addr       <= '0;
         r_mem_we         <= 1'b0;
         r_mem_be         <= '0;
         r_mem_wdata      <= '0;
         r_rsp_valid      <= 1'b0;
         r_rsp_data       <= '0;
         r_rsp_type       <= '0;
         r_rsp_offset     <= '0;
         r_rsp_misaligned <= 1'b0;
         r_rsp_timeout    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write      <= req_write;
                  r_rsp_type   <= req_type;
                  r_rsp_offset <= req_addr[1:0];
                  r_rsp_data   <= '0;
                  if (w_reject) begin
                     r_rsp_valid      <= 1'b1;
                     r_rsp_misaligned <= 1'b1;
                  end else begin
                     r_mem_req_valid <= 1'b1;
                     r_mem_addr      <= {req_addr[31:2], 2'b00};
                     r_mem_we        <= req_write;
                     r_mem_be        <= w_enc_be;
                     r_mem_wdata     <= req_write ? w_enc_wdata : 32'h0;
                  end
               end
            end
            ST_REQ: begin
               // Bus fields hold until accepted, then the bus is left quiet
               if (mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_mem_addr      <= '0;
                  r_mem_we        <= 1'b0;
                  r_mem_be        <= '0;
                  r_mem_wdata     <= '0;
               end
            end
            ST_WAIT: begin
               if (mem_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_write ? 32'h0 : mem_rdata;
               end else if (w_timeout_hit) begin
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b1;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  r_rsp_valid      <= 1'b0;
                  r_rsp_misaligned <= 1'b0;
                  r_rsp_timeout    <= 1'b0;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = (r_state == ST_IDLE);
   assign mem_req_valid  = r_mem_req_valid;
   assign mem_addr       = r_mem_addr;
   assign mem_we         = r_mem_we;
   assign mem_be         = r_mem_be;
   assign mem_wdata      = r_mem_wdata;
   assign rsp_valid      = r_rsp_valid;
   assign rsp_data       = r_rsp_data;
   assign rsp_type       = r_rsp_type;
   assign rsp_offset     = r_rsp_offset;
   assign rsp_misaligned = r_rsp_misaligned;
   assign rsp_timeout    = r_rsp_timeout;

endmodule

// File: tb/tb_data_memory_interface.sv
// Bench for data_memory_interface: table of accesses plus stall, timeout and reset sequences.
// Bus and consumer are modelled at the falling edge; expectations flow through queues.
// Timeout limit is set to 4 so the abandon path is reachable quickly.
module tb_data_memory_interface;
   import data_memory_interface_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  typ;
      logic [1:0]  off;
      logic        mis;
      logic        tmo;
   } rsp_t;

   typedef struct {
      string       name;
      logic        write;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        has_bus;
      bus_t        bus;
      rsp_t        rsp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data;
   logic [2:0]  rsp_type;
   logic [1:0]  rsp_offset;
   logic        rsp_misaligned;
   logic        rsp_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bus_t exp_bus_q[$];
   rsp_t exp_rsp_q[$];

   // Bus / consumer model controls
   logic        bus_rsp_en = 1'b1;
   int          bus_rsp_delay = 0;
   int          bus_stall = 0;
   int          bus_pend = 0;
   logic        bus_stray = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   int          rsp_stall = 0;
   int          acc_cyc = 0;
   int          req_rise_cyc = -1;
   int          rsp_rise_cyc = -1;

   data_memory_interface #(.TIMEOUT_CYCLES(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_type       (req_type),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_be         (mem_be),
      .mem_wdata      (mem_wdata),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rdata      (mem_rdata),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_data       (rsp_data),
      .rsp_type       (rsp_type),
      .rsp_offset     (rsp_offset),
      .rsp_misaligned (rsp_misaligned),
      .rsp_timeout    (rsp_timeout)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input string name, input logic w, input logic [2:0] t,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                               input logic hb, input logic [31:0] baddr, input logic [3:0] be,
                               input logic [31:0] bwd, input logic [31:0] rdat, input logic mis);
      vec_t v;
      v.name = name; v.write = w; v.typ = t; v.addr = a; v.wdata = wd; v.rdata = rd;
      v.has_bus = hb;
      v.bus = {baddr, w, be, bwd};
      v.rsp = {rdat, t, a[1:0], mis, 1'b0};
      return v;
   endfunction

   function automatic logic [109:0] all_out();
      return {mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid,
              rsp_data, rsp_type, rsp_offset, rsp_misaligned, rsp_timeout};
   endfunction

   // Bus slave and result consumer, both acting at the falling edge
   initial begin : monitor
      bus_t p_bus, cur_bus, eb;
      rsp_t p_rsp, cur_rsp, er;
      logic p_mvalid, p_mready, p_rvalid, p_rready;
      p_mvalid = 0; p_mready = 0; p_rvalid = 0; p_rready = 0;
      p_bus = '0; p_rsp = '0;
      forever begin
         @(negedge clk);
         cur_bus = {mem_addr, mem_we, mem_be, mem_wdata};
         cur_rsp = {rsp_data, rsp_type, rsp_offset, rsp_misaligned, rsp_timeout};
         if (!rst_n) begin
            p_mvalid = 0; p_mready = 0; p_rvalid = 0; p_rready = 0;
            bus_pend = 0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b1; rsp_ready = 1'b1;
            continue;
         end
         // bus request accepted at the previous rising edge
         if (p_mvalid && p_mready) begin
            checks++;
            if (exp_bus_q.size() == 0) begin
               errors++;
               $display("FAIL bus_req: unexpected request addr=%h be=%h", p_bus.addr, p_bus.be);
            end else begin
               eb = exp_bus_q.pop_front();
               if (p_bus !== eb) begin
                  errors++;
                  $display("FAIL bus_req: got addr=%h we=%b be=%h wdata=%h, want addr=%h we=%b be=%h wdata=%h",
                           p_bus.addr, p_bus.we, p_bus.be, p_bus.wdata, eb.addr, eb.we, eb.be, eb.wdata);
               end
            end
            if (bus_rsp_en) bus_pend = bus_rsp_delay + 1;
         end
         if (p_mvalid && !p_mready) begin
            checks++;
            if (mem_req_valid !== 1'b1 || cur_bus !== p_bus || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL bus_stall_stable: got valid=%b bus=%h req_ready=%b, want valid=1 bus=%h req_ready=0",
                        mem_req_valid, cur_bus, req_ready, p_bus);
            end
         end
         if (p_rvalid && !p_rready) begin
            checks++;
            if (rsp_valid !== 1'b1 || cur_rsp !== p_rsp) begin
               errors++;
               $display("FAIL rsp_stall_stable: got valid=%b rsp=%h, want valid=1 rsp=%h", rsp_valid, cur_rsp, p_rsp);
            end
         end
         if (mem_req_valid && !p_mvalid) req_rise_cyc = cyc;
         if (rsp_valid && !p_rvalid) rsp_rise_cyc = cyc;
         // response pulse
         mem_rsp_valid = 1'b0;
         if (bus_pend > 0) begin
            bus_pend--;
            if (bus_pend == 0) begin
               mem_rsp_valid = 1'b1;
               mem_rdata = bus_rdata;
            end
         end
         if (bus_stray) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = 32'hBAD0BAD0;
            bus_stray = 1'b0;
         end
         if (mem_req_valid && bus_stall > 0) begin
            mem_req_ready = 1'b0;
            bus_stall--;
         end else begin
            mem_req_ready = 1'b1;
         end
         // consumer
         if (rsp_valid) begin
            checks++;
            if (req_ready !== 1'b0) begin
               errors++;
               $display("FAIL req_ready_busy: got %b, want 0 while result pending", req_ready);
            end
            if (rsp_stall > 0) begin
               rsp_ready = 1'b0;
               rsp_stall--;
            end else begin
               rsp_ready = 1'b1;
               checks++;
               if (exp_rsp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rsp: unexpected result rsp=%h", cur_rsp);
               end else begin
                  er = exp_rsp_q.pop_front();
                  if (cur_rsp !== er) begin
                     errors++;
                     $display("FAIL rsp: got data=%h type=%0d off=%0d mis=%b tmo=%b, want data=%h type=%0d off=%0d mis=%b tmo=%b",
                              cur_rsp.data, cur_rsp.typ, cur_rsp.off, cur_rsp.mis, cur_rsp.tmo,
                              er.data, er.typ, er.off, er.mis, er.tmo);
                  end
               end
            end
         end else begin
            rsp_ready = 1'b1;
         end
         p_mvalid = mem_req_valid; p_mready = mem_req_ready; p_bus = cur_bus;
         p_rvalid = rsp_valid; p_rready = rsp_ready; p_rsp = cur_rsp;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic start_req(input vec_t v);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         errors++;
         $display("FAIL %s_ready: req_ready never rose, got %b want 1", v.name, req_ready);
      end
      bus_rdata = v.rdata;
      if (v.has_bus) exp_bus_q.push_back(v.bus);
      req_valid = 1'b1; req_write = v.write; req_type = v.typ;
      req_addr = v.addr; req_wdata = v.wdata;
      req_rise_cyc = -1; rsp_rise_cyc = -1;
      @(negedge clk);
      acc_cyc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic do_req(input vec_t v);
      int n;
      exp_rsp_q.push_back(v.rsp);
      start_req(v);
      n = 0;
      while ((exp_rsp_q.size() != 0 || exp_bus_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s_done: got %0d results and %0d bus requests outstanding, want 0",
                  v.name, exp_rsp_q.size(), exp_bus_q.size());
         exp_rsp_q.delete();
         exp_bus_q.delete();
      end
   endtask

   initial begin : stim
      vec_t tbl[11];
      vec_t v;
      int n;
      tbl[0]  = mk("lw_100",  0, MEM_W,  32'h100, 32'h0,        32'hDEADBEEF, 1, 32'h100, 4'hF, 32'h0,        32'hDEADBEEF, 0);
      tbl[1]  = mk("sb_203",  1, MEM_B,  32'h203, 32'h000000A5, 32'h0,        1, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0,        0);
      tbl[2]  = mk("lh_101",  0, MEM_H,  32'h101, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1);
      tbl[3]  = mk("sw_102",  1, MEM_W,  32'h102, 32'h12345678, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1);
      tbl[4]  = mk("sh_202",  1, MEM_H,  32'h202, 32'h1234BEEF, 32'h0,        1, 32'h200, 4'hC, 32'hBEEFBEEF, 32'h0,        0);
      tbl[5]  = mk("lbu_305", 0, MEM_BU, 32'h305, 32'h0,        32'h11223344, 1, 32'h304, 4'h2, 32'h0,        32'h11223344, 0);
      tbl[6]  = mk("lhu_106", 0, MEM_HU, 32'h106, 32'h0,        32'h55667788, 1, 32'h104, 4'hC, 32'h0,        32'h55667788, 0);
      tbl[7]  = mk("sbu_400", 1, MEM_BU, 32'h400, 32'h000000FF, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1);
      tbl[8]  = mk("lb_007",  0, MEM_B,  32'h007, 32'h0,        32'hCAFEBABE, 1, 32'h004, 4'h8, 32'h0,        32'hCAFEBABE, 0);
      tbl[9]  = mk("sw_010",  1, MEM_W,  32'h010, 32'hCAFEF00D, 32'h0,        1, 32'h010, 4'hF, 32'hCAFEF00D, 32'h0,        0);
      tbl[10] = mk("lh_103",  0, MEM_H,  32'h103, 32'h0,        32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1);

      // reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'(all_out() != '0), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'd1);

      for (int i = 0; i < 11; i++) begin
         do_req(tbl[i]);
         if (tbl[i].has_bus) begin
            check({tbl[i].name, "_req_lat"}, 64'(req_rise_cyc - acc_cyc), 64'd0);
            if (tbl[i].name == "lw_100")
               check("lw_100_rsp_lat", 64'(rsp_rise_cyc - acc_cyc), 64'd2);
         end else begin
            check({tbl[i].name, "_no_bus"}, 64'(req_rise_cyc), 64'(-1));
            check({tbl[i].name, "_rsp_lat"}, 64'(rsp_rise_cyc - acc_cyc), 64'd0);
         end
      end

      // bus stall: request fields held while mem_req_ready is low
      bus_stall = 5;
      do_req(mk("sh_stall", 1, MEM_H, 32'h20A, 32'h0000ABCD, 32'h0, 1, 32'h208, 4'hC, 32'hABCDABCD, 32'h0, 0));
      check("bus_stall_consumed", 64'(bus_stall), 64'd0);

      // consumer stall: result held while rsp_ready is low
      rsp_stall = 4;
      do_req(mk("lw_rstall", 0, MEM_W, 32'h44, 32'h0, 32'h0BADF00D, 1, 32'h44, 4'hF, 32'h0, 32'h0BADF00D, 0));
      check("rsp_stall_consumed", 64'(rsp_stall), 64'd0);

      // response on the last WAIT cycle before the limit completes normally
      bus_rsp_delay = 3;
      do_req(mk("lw_late_ok", 0, MEM_W, 32'h48, 32'h0, 32'h13579BDF, 1, 32'h48, 4'hF, 32'h0, 32'h13579BDF, 0));

      // timeout; the response that arrives afterwards must be dropped
      bus_rsp_delay = 8;
      v = mk("lw_tmo", 0, MEM_W, 32'h500, 32'h0, 32'h77777777, 1, 32'h500, 4'hF, 32'h0, 32'h0, 0);
      v.rsp.tmo = 1'b1;
      do_req(v);
      n = 0;
      while (bus_pend != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus_rsp_delay = 0;
      bus_stray = 1'b1;
      repeat (3) @(negedge clk);
      check("stray_ignored", {62'd0, rsp_valid, req_ready}, 64'd1);
      do_req(mk("lw_after", 0, MEM_W, 32'h504, 32'h0, 32'h2468ACE0, 1, 32'h504, 4'hF, 32'h0, 32'h2468ACE0, 0));

      // reset while waiting on the bus
      bus_rsp_en = 1'b0;
      start_req(mk("lw_rst", 0, MEM_W, 32'h600, 32'h0, 32'h0, 1, 32'h600, 4'hF, 32'h0, 32'h0, 0));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", 64'(all_out() != '0), 64'd0);
      exp_rsp_q.delete();
      check("midrst_bus_done", 64'(exp_bus_q.size()), 64'd0);
      exp_bus_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus_rsp_en = 1'b1;
      @(negedge clk);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      check("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      do_req(mk("lbu_702", 0, MEM_BU, 32'h702, 32'h0, 32'h8899AABB, 1, 32'h700, 4'h4, 32'h0, 32'h8899AABB, 0));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
